seg_display_decoder: RTL and testbench
======================================

# seg_display_decoder

Receive-side counterpart of the multiplexed seven-segment driver in the parking system. It samples the shared segment bus (segment pattern plus one-hot digit select) and filters out switching glitches. It decodes each stable pattern back to a BCD digit and reports a complete 4-digit frame. It sits on the board-level display bus as a monitor/loopback checker, feeding the self-test logic and the verification bench.

## Interface

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits; fixed at 4 in this revision.
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is accepted; legal range 2–255.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- set_Data  in  8  segment pattern; bit0=a … bit6=g, bit7=dp, active-high.
- see_sel  in  5  digit select, one-hot.
  - 5'b01000 selects digit0, 5'b00100 digit1, 5'b00010 digit2, 5'b00001 digit3.
  - Bit4 is unused and must be 0.
- digits  out  16  decoded nibbles; digit0 in [3:0] through digit3 in [15:12].
- digit_valid  out  4  bit i=1 when the last capture of digit i decoded to 0–9.
- dp  out  4  bit i holds the dp bit from the last capture of digit i.
- frame_valid  out  1  one-cycle pulse when all four digits have been captured since the last frame or reset.
- seg_error  out  1  one-cycle pulse when a capture holds an unrecognised pattern.
- sel_error  out  1  one-cycle pulse when a stable non-zero see_sel is not a legal one-hot code.

## Operation

- Sample register:
  - Each edge, s_reg <= {see_sel, set_Data}.
  - If the inputs equal s_reg, cnt <= cnt+1, saturating at STABLE_CYCLES; otherwise cnt <= 1.
- Capture strobe:
  - Asserted in the cycle where cnt first equals STABLE_CYCLES and s_reg's select field is non-zero.
  - Fires exactly once per stable run; a held value never recaptures.
- see_sel == 0: bus idle; no capture, no error.
- Illegal select (bit4 set, or more than one bit set): on the strobe, pulse sel_error. digits, digit_valid, dp and the seen mask are unchanged.
- Decode uses set_Data[6:0]; dp is taken separately.
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x6F→9: nibble written, digit_valid[i]=1.
  - 0x00 (blank): nibble 4'hF, digit_valid[i]=0, no error.
  - Any other pattern: nibble 4'hE, digit_valid[i]=0, seg_error pulse.
- Seen mask (4 bits):
  - Bit i is set on every legal capture of digit i, including blank and error captures.
  - Recapturing a digit before the frame completes only overwrites its value.
  - When a capture makes the mask 4'b1111: frame_valid pulses and the mask clears to 0 on the same edge.
  - The mask update and frame_valid take effect on the capture-strobe edge, the same edge as the data update.

## Timing

- Reset values: digits=16'hFFFF, digit_valid=0, dp=0, frame_valid=0, seg_error=0, sel_error=0, mask=0, cnt=0, s_reg=0.
- A new bus value first present at edge E1 gives cnt=1 after E1, and cnt=STABLE_CYCLES after edge E_STABLE_CYCLES.
- Outputs update at edge E_(STABLE_CYCLES+1), i.e. latency STABLE_CYCLES+1 edges (5 by default).
- Pulses (frame_valid, seg_error, sel_error) are high for exactly one cycle.
- A value held for fewer than STABLE_CYCLES edges is discarded.
- rst mid-frame:
  - Clears mask, cnt and all outputs at that edge.
  - Any strobe pending in the same cycle is dropped; rst has priority.
- Back-to-back digits with no idle gap are legal. Each needs its own STABLE_CYCLES run.

## Test plan

- Reset: assert rst 2 cycles with random bus → digits=16'hFFFF, all other outputs 0.
- Single digit: see_sel=5'b01000, set_Data=0x5B held 10 cycles.
  - Required: digits[3:0]=2 and digit_valid=4'b0001 at edge 5.
  - Required: no further change, frame_valid stays 0.
- Full frame: digits 1,2,3,4 (0x06, 0x5B, 0x4F, 0x66) each held 20 cycles on selects 01000, 00100, 00010, 00001.
  - Required: digits=16'h4321, digit_valid=4'hF.
  - Required: exactly one frame_valid pulse, on the 4th capture.
- Glitch rejection: 0x7F held 3 cycles, then 0x06 held 8 cycles on digit0 → digits[3:0]=1 only; 8 is never captured.
- Errors:
  - see_sel=5'b01100 held 8 cycles → one sel_error pulse, outputs unchanged.
  - 0x77 on digit2 → digits[11:8]=E, digit_valid[2]=0, one seg_error pulse.
- Reset mid-frame: capture digit0 and digit1, pulse rst, then capture digit2 and digit3.
  - Required: no frame_valid.
  - Recapturing digit0 and digit1 afterwards → frame_valid pulses once.

Source files
------------

// File: rtl/seg_display_decoder_if.sv
// Display bus seen by the decoder: sampled segment/select lines plus decoded results.
interface seg_display_decoder_if;
  logic [7:0]  set_Data;
  logic [4:0]  see_sel;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic [3:0]  dp;
  logic        frame_valid;
  logic        seg_error;
  logic        sel_error;

  // Bus driver side: drives segment/select lines, observes decoded results.
  modport master (
    output set_Data, see_sel,
    input  digits, digit_valid, dp, frame_valid, seg_error, sel_error
  );

  // Decoder side.
  modport slave (
    input  set_Data, see_sel,
    output digits, digit_valid, dp, frame_valid, seg_error, sel_error
  );
endinterface

// File: rtl/seg_display_decoder.sv
// Seven-segment bus monitor: deglitches the multiplexed bus, decodes each stable
// pattern to BCD and reports complete 4-digit frames.
module seg_display_decoder #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input logic                 clk,
  input logic                 rst,
  seg_display_decoder_if.slave bus
);

  localparam int unsigned SAMPLE_W = 13;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned NIB_W    = 4;

  logic [SAMPLE_W-1:0]   s_reg, s_reg_n, sample_c;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic                  fired, fired_n;
  logic [15:0]           digits_q, digits_n;
  logic [NUM_DIGITS-1:0] dvalid_q, dvalid_n;
  logic [NUM_DIGITS-1:0] dp_q, dp_n;
  logic [NUM_DIGITS-1:0] mask_q, mask_n, mask_set_c, oh_c;
  logic                  frame_q, frame_n;
  logic                  seg_err_q, seg_err_n;
  logic                  sel_err_q, sel_err_n;

  logic                  same_c, strobe_c, legal_c, dv_c, bad_c;
  logic [4:0]            sel_c;
  logic [7:0]            pat_c;
  logic [1:0]            idx_c;
  logic [NIB_W-1:0]      nib_c;

  assign sample_c = {bus.see_sel, bus.set_Data};
  assign same_c   = (sample_c == s_reg);
  assign sel_c    = s_reg[12:8];
  assign pat_c    = s_reg[7:0];
  // fired blocks a second strobe while the same value is held past saturation
  assign strobe_c = (cnt == CNT_W'(STABLE_CYCLES)) && !fired && (sel_c != 5'b0);
  assign legal_c  = !sel_c[4] && $onehot(sel_c[3:0]);
  // select bit 3 is digit0, bit 0 is digit3
  assign oh_c     = NUM_DIGITS'({sel_c[0], sel_c[1], sel_c[2], sel_c[3]});

  // Digit index of the captured one-hot select.
  always_comb begin
    idx_c = 2'd3;
    case (sel_c[3:0])
      4'b1000: idx_c = 2'd0;
      4'b0100: idx_c = 2'd1;
      4'b0010: idx_c = 2'd2;
      default: idx_c = 2'd3;
    endcase
  end

  // Segment pattern to BCD; blank and unknown get distinct marker nibbles.
  always_comb begin
    nib_c = 4'hE;
    dv_c  = 1'b1;
    bad_c = 1'b0;
    case (pat_c[6:0])
      7'h3F: nib_c = 4'd0;
      7'h06: nib_c = 4'd1;
      7'h5B: nib_c = 4'd2;
      7'h4F: nib_c = 4'd3;
      7'h66: nib_c = 4'd4;
      7'h6D: nib_c = 4'd5;
      7'h7D: nib_c = 4'd6;
      7'h07: nib_c = 4'd7;
      7'h7F: nib_c = 4'd8;
      7'h6F: nib_c = 4'd9;
      7'h00: begin
        nib_c = 4'hF;
        dv_c  = 1'b0;
      end
      default: begin
        nib_c = 4'hE;
        dv_c  = 1'b0;
        bad_c = 1'b1;
      end
    endcase
  end

  // Next-state: stability counter, capture, seen mask and event pulses.
  always_comb begin
    s_reg_n    = sample_c;
    cnt_n      = same_c ? ((cnt == CNT_W'(STABLE_CYCLES)) ? cnt : cnt + CNT_W'(1))
                        : CNT_W'(1);
    fired_n    = same_c && (fired || strobe_c);
    digits_n   = digits_q;
    dvalid_n   = dvalid_q;
    dp_n       = dp_q;
    mask_n     = mask_q;
    frame_n    = 1'b0;
    seg_err_n  = 1'b0;
    sel_err_n  = 1'b0;
    mask_set_c = mask_q | oh_c;
    if (strobe_c) begin
      if (!legal_c) begin
        sel_err_n = 1'b1;
      end else begin
        digits_n[{idx_c, 2'b00} +: NIB_W] = nib_c;
        dvalid_n[idx_c] = dv_c;
        dp_n[idx_c]     = pat_c[7];
        seg_err_n       = bad_c;
        if (&mask_set_c) begin
          frame_n = 1'b1;
          mask_n  = '0;
        end else begin
          mask_n = mask_set_c;
        end
      end
    end
  end

  // State and output registers; reset overrides any pending capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_reg     <= '0;
      cnt       <= '0;
      fired     <= 1'b0;
      digits_q  <= 16'hFFFF;
      dvalid_q  <= '0;
      dp_q      <= '0;
      mask_q    <= '0;
      frame_q   <= 1'b0;
      seg_err_q <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      s_reg     <= s_reg_n;
      cnt       <= cnt_n;
      fired     <= fired_n;
      digits_q  <= digits_n;
      dvalid_q  <= dvalid_n;
      dp_q      <= dp_n;
      mask_q    <= mask_n;
      frame_q   <= frame_n;
      seg_err_q <= seg_err_n;
      sel_err_q <= sel_err_n;
    end
  end

  assign bus.digits      = digits_q;
  assign bus.digit_valid = dvalid_q;
  assign bus.dp          = dp_q;
  assign bus.frame_valid = frame_q;
  assign bus.seg_error   = seg_err_q;
  assign bus.sel_error   = sel_err_q;

endmodule

// File: tb/tb_seg_display_decoder.sv
// Directed bench for seg_display_decoder with hand-computed expectations.
module tb_seg_display_decoder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   fv_total;
  int   seg_total;
  int   sel_total;
  int   fv_base;
  int   seg_base;
  int   sel_base;

  seg_display_decoder_if bus ();

  seg_display_decoder #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count high samples of each pulse output, away from the active edge.
  initial begin
    fv_total  = 0;
    seg_total = 0;
    sel_total = 0;
    forever begin
      @(negedge clk);
      fv_total  += int'(bus.frame_valid);
      seg_total += int'(bus.seg_error);
      sel_total += int'(bus.sel_error);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive the bus at a falling edge and hold it for n clock edges.
  task automatic hold(input logic [4:0] sel, input logic [7:0] data, input int n);
    bus.see_sel  = sel;
    bus.set_Data = data;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.see_sel  = 5'($urandom);
    bus.set_Data = 8'($urandom);
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_digits", 32'(bus.digits), 32'hFFFF);
    check("rst_valid", 32'(bus.digit_valid), 32'h0);
    check("rst_dp", 32'(bus.dp), 32'h0);
    check("rst_frame", 32'(bus.frame_valid), 32'h0);
    check("rst_seg_err", 32'(bus.seg_error), 32'h0);
    check("rst_sel_err", 32'(bus.sel_error), 32'h0);
    rst = 1'b0;
    hold(5'b00000, 8'h00, 3);

    // Single digit: nothing before edge 5, captured at edge 5, then stable
    fv_base = fv_total;
    hold(5'b01000, 8'h5B, 4);
    check("single_before_e5", 32'(bus.digits), 32'hFFFF);
    hold(5'b01000, 8'h5B, 1);
    check("single_digit0", 32'(bus.digits[3:0]), 32'h2);
    check("single_valid", 32'(bus.digit_valid), 32'h1);
    hold(5'b01000, 8'h5B, 5);
    check("single_hold", 32'(bus.digits), 32'hFFF2);
    check("single_no_frame", 32'(fv_total - fv_base), 32'd0);

    // Full frame, one pulse only on the fourth capture
    fv_base = fv_total;
    hold(5'b01000, 8'h06, 20);
    hold(5'b00100, 8'h5B, 20);
    hold(5'b00010, 8'h4F, 20);
    check("frame_before_4th", 32'(fv_total - fv_base), 32'd0);
    hold(5'b00001, 8'h66, 20);
    check("frame_digits", 32'(bus.digits), 32'h4321);
    check("frame_valid_mask", 32'(bus.digit_valid), 32'hF);
    check("frame_pulses", 32'(fv_total - fv_base), 32'd1);

    // Glitch rejection
    hold(5'b01000, 8'h6D, 8);
    check("glitch_setup", 32'(bus.digits), 32'h4325);
    hold(5'b01000, 8'h7F, 3);
    hold(5'b01000, 8'h06, 3);
    hold(5'b00000, 8'h5B, 6);
    check("glitch_short_runs", 32'(bus.digits), 32'h4325);
    hold(5'b01000, 8'h7F, 3);
    hold(5'b01000, 8'h06, 8);
    check("glitch_digit0", 32'(bus.digits), 32'h4321);

    // Illegal selects
    sel_base = sel_total;
    hold(5'b01100, 8'h3F, 8);
    check("sel_err_pulse", 32'(sel_total - sel_base), 32'd1);
    check("sel_err_digits", 32'(bus.digits), 32'h4321);
    check("sel_err_valid", 32'(bus.digit_valid), 32'hF);
    hold(5'b10000, 8'h06, 8);
    check("sel_bit4_pulse", 32'(sel_total - sel_base), 32'd2);
    hold(5'b00000, 8'h00, 2);

    // Unknown pattern, blank, dp; these captures complete the frame
    seg_base = seg_total;
    fv_base  = fv_total;
    hold(5'b00010, 8'h77, 8);
    check("seg_err_digits", 32'(bus.digits), 32'h4E21);
    check("seg_err_valid", 32'(bus.digit_valid), 32'hB);
    check("seg_err_pulse", 32'(seg_total - seg_base), 32'd1);
    hold(5'b00001, 8'h00, 8);
    check("blank_digits", 32'(bus.digits), 32'hFE21);
    check("blank_valid", 32'(bus.digit_valid), 32'h3);
    check("blank_no_seg_err", 32'(seg_total - seg_base), 32'd1);
    check("blank_no_frame", 32'(fv_total - fv_base), 32'd0);
    hold(5'b00100, 8'hBF, 8);
    check("dp_digits", 32'(bus.digits), 32'hFE01);
    check("dp_bits", 32'(bus.dp), 32'h2);
    check("dp_frame", 32'(fv_total - fv_base), 32'd1);

    // Reset mid-frame, including a strobe pending at the reset edge
    fv_base = fv_total;
    hold(5'b01000, 8'h07, 8);
    hold(5'b00100, 8'h7D, 8);
    check("mid_pre_digits", 32'(bus.digits), 32'hFE67);
    hold(5'b00010, 8'h3F, 4);
    rst = 1'b1;
    hold(5'b00010, 8'h3F, 1);
    rst = 1'b0;
    check("mid_rst_digits", 32'(bus.digits), 32'hFFFF);
    check("mid_rst_valid", 32'(bus.digit_valid), 32'h0);
    check("mid_rst_dp", 32'(bus.dp), 32'h0);
    hold(5'b00000, 8'h00, 2);
    hold(5'b00010, 8'h3F, 8);
    hold(5'b00001, 8'h6F, 8);
    check("mid_no_frame", 32'(fv_total - fv_base), 32'd0);
    check("mid_half_digits", 32'(bus.digits), 32'h90FF);
    hold(5'b01000, 8'h07, 8);
    hold(5'b00100, 8'h7D, 8);
    check("mid_frame", 32'(fv_total - fv_base), 32'd1);
    check("mid_digits", 32'(bus.digits), 32'h9067);
    check("mid_valid", 32'(bus.digit_valid), 32'hF);
    hold(5'b00000, 8'h00, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
